stage_chain_engine: RTL and testbench

- Sequential, parametrised successor to the single-stage pass/bonus evaluator.
- Runs one game attempt through NUM_STAGES stages, one stage per accepted input beat.
- Carries the bonus from each stage into the next and reports one final result per run.
- Sits between the stimulus/attempt generator and the scoreboard/result logger.

---
 rtl/stage_chain_engine.sv | 102 ++++++++++
 tb/tb_stage_chain_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stage_chain_engine.sv
// stage_chain_engine: multi-stage pass/bonus evaluator carrying bonus between stages, one result per run.
// Optional overwork check enabled by defining STAGE_CHAIN_LIVER_CHECK_EN.
module stage_chain_engine #(
  parameter int NUM_STAGES  = 4,
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = 100,
  parameter int BONUS_W     = 2,
  parameter int BONUS_STEP  = 4,
  parameter int BONUS_SHIFT = 5,
  parameter int LIVER_LIMIT = 95,
  parameter int LIVER_RUN   = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 start,
  input  logic                                                 abort,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [SCORE_W-1:0]                                   effort,
  input  logic [SCORE_W-1:0]                                   hard,
  input  logic [BONUS_W-1:0]                                   luck,
  output logic                                                 busy,
  output logic [(NUM_STAGES > 2 ? $clog2(NUM_STAGES) : 1)-1:0] stage_idx,
  output logic                                                 res_valid,
  output logic                                                 pass,
  output logic [BONUS_W-1:0]                                   final_bonus,
  output logic [(NUM_STAGES > 2 ? $clog2(NUM_STAGES) : 1)-1:0] fail_stage,
  output logic                                                 liver_fail
);
  localparam int IW = NUM_STAGES > 2 ? $clog2(NUM_STAGES) : 1;
  localparam int AW = SCORE_W + 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [BONUS_W-1:0] bonus, bonus_next;
  logic [AW-1:0] total, score, bonus_wide;
  logic stage_pass, beat, last, fail, ovw, go;
  assign total      = AW'(effort) + AW'(bonus) * AW'(BONUS_STEP) + AW'(luck) * AW'(BONUS_STEP);
  assign score      = total > AW'(MAX_SCORE) ? AW'(MAX_SCORE) : total;
  assign stage_pass = score > AW'(hard);
  assign bonus_wide = total >> BONUS_SHIFT;
  assign bonus_next = bonus_wide > AW'((1 << BONUS_W) - 1) ? '1 : bonus_wide[BONUS_W-1:0];
  assign go         = state == IDLE && start;
  assign beat       = state == RUN && in_valid && !abort;
  assign last       = stage_idx == IW'(NUM_STAGES - 1);
  assign fail       = !stage_pass || ovw;
`ifdef STAGE_CHAIN_LIVER_CHECK_EN
  localparam int CW = $clog2(LIVER_RUN + 1);
  logic [CW-1:0] run_cnt;
  logic heavy;
  assign heavy = effort >= SCORE_W'(LIVER_LIMIT);
  // the beat that brings the streak to LIVER_RUN is the one that fails
  assign ovw = heavy && (run_cnt + 1'b1) == CW'(LIVER_RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_cnt <= '0;
    else if (go) run_cnt <= '0;
    else if (beat) run_cnt <= heavy ? run_cnt + 1'b1 : '0;
`else
  assign ovw = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE)
              : state == RUN  ? (abort ? IDLE : (beat && (fail || last)) ? DONE : RUN)
              : IDLE;
  end
  always_comb begin
    in_ready  = state == RUN;
    busy      = state != IDLE;
    res_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bonus       <= '0;
      stage_idx   <= '0;
      pass        <= 1'b0;
      final_bonus <= '0;
      fail_stage  <= '0;
      liver_fail  <= 1'b0;
    end else if (go) begin
      bonus       <= '0;
      stage_idx   <= '0;
      pass        <= 1'b0;
      final_bonus <= '0;
      fail_stage  <= '0;
      liver_fail  <= 1'b0;
    end else if (beat) begin
      if (fail) begin
        pass        <= 1'b0;
        fail_stage  <= stage_idx;
        final_bonus <= '0;
        liver_fail  <= ovw;
      end else if (last) begin
        pass        <= 1'b1;
        final_bonus <= bonus_next;
      end else begin
        stage_idx <= stage_idx + 1'b1;
        bonus     <= bonus_next;
      end
    end
endmodule

// File: tb/tb_stage_chain_engine.sv
// tb_stage_chain_engine: directed checks of stage_chain_engine with a result scoreboard fed by a reference model.
module tb_stage_chain_engine;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
  logic [6:0] effort = 0, hard = 0;
  logic [1:0] luck = 0;
  logic in_ready, busy, res_valid, pass, liver_fail;
  logic [1:0] stage_idx, final_bonus, fail_stage;
  typedef struct {logic p; logic [1:0] fb; logic [1:0] fs; logic lf;} res_t;
  res_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int m_bonus = 0, m_stage = 0, m_cnt = 0;
  bit m_active = 0;

  stage_chain_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .effort(effort), .hard(hard), .luck(luck), .busy(busy),
    .stage_idx(stage_idx), .res_valid(res_valid), .pass(pass), .final_bonus(final_bonus),
    .fail_stage(fail_stage), .liver_fail(liver_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1;
    if (!m_active) begin
      m_active = 1; m_bonus = 0; m_stage = 0; m_cnt = 0;
    end
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("stage_after_start", stage_idx, m_stage);
  endtask

  // drive one beat; the model decides whether it ends the run and queues the expected result
  task automatic send(input int e, input int h, input int l);
    int total, score, nb;
    bit ovw, decided;
    res_t r;
    decided = 0; ovw = 0;
    chk("in_ready", in_ready, m_active);
    effort = 7'(e); hard = 7'(h); luck = 2'(l); in_valid = 1;
    if (m_active) begin
      total = e + 4 * m_bonus + 4 * l;
      score = total > 100 ? 100 : total;
      nb = total / 32 > 3 ? 3 : total / 32;
`ifdef STAGE_CHAIN_LIVER_CHECK_EN
      if (e >= 95) begin m_cnt++; ovw = m_cnt == 3; end else m_cnt = 0;
`endif
      if (score <= h || ovw) begin
        exp_q.push_back('{1'b0, 2'd0, 2'(m_stage), ovw}); decided = 1; m_active = 0;
      end else if (m_stage == 3) begin
        exp_q.push_back('{1'b1, 2'(nb), 2'd0, 1'b0}); decided = 1; m_active = 0;
      end else begin
        m_stage++; m_bonus = nb;
      end
    end
    @(negedge clk);
    in_valid = 0;
    if (decided) begin
      chk("res_latency", res_valid, 1);
      r = exp_q.pop_front();
      chk("sb_pass", pass, r.p);
      chk("sb_final_bonus", final_bonus, r.fb);
      chk("sb_fail_stage", fail_stage, r.fs);
      chk("sb_liver_fail", liver_fail, r.lf);
      @(negedge clk);
      chk("res_one_cycle", res_valid, 0);
      chk("busy_after_done", busy, 0);
    end else begin
      chk("no_res", res_valid, 0);
      if (m_active) chk("stage_idx", stage_idx, m_stage);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_stage", stage_idx, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_stage", fail_stage, 0);
    rst_n = 1;
    @(negedge clk);
    // 1: four passing stages, bonus saturates at 3
    do_start();
    repeat (4) send(90, 50, 0);
    chk("t1_pass", pass, 1);
    chk("t1_final_bonus", final_bonus, 3);
    chk("t1_fail_stage", fail_stage, 0);
    // 2: fail at stage 1, later beats refused
    do_start();
    send(90, 50, 0);
    send(10, 50, 0);
    chk("t2_fail_stage", fail_stage, 1);
    chk("t2_pass", pass, 0);
    chk("t2_in_ready", in_ready, 0);
    send(90, 50, 0);
    // 3: saturation at the strict compare boundary
    do_start();
    send(100, 50, 3);
    send(100, 100, 3);
    chk("t3a_fail_stage", fail_stage, 1);
    do_start();
    send(100, 50, 3);
    send(100, 99, 3);
    send(80, 50, 0);
    send(80, 50, 0);
    chk("t3b_pass", pass, 1);
    chk("t3b_final_bonus", final_bonus, 2);
    // 4: handshake rules
    in_valid = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_pass_held", pass, 1);
    chk("t4_idle_fb_held", final_bonus, 2);
    do_start();
    send(90, 50, 0);
    do_start();
    send(90, 50, 0);
    abort = 1; in_valid = 1;
    @(negedge clk);
    abort = 0; in_valid = 0; m_active = 0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_res", res_valid, 0);
    chk("t4_abort_pass", pass, 0);
    @(negedge clk);
    chk("t4_abort_no_res", res_valid, 0);
    // 5: asynchronous reset mid-run, then a clean run
    do_start();
    send(90, 50, 0);
    send(90, 50, 0);
    rst_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_stage", stage_idx, 0);
    chk("t5_res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1; m_active = 0;
    @(negedge clk);
    do_start();
    repeat (4) send(90, 50, 0);
    chk("t5_pass", pass, 1);
    chk("t5_final_bonus", final_bonus, 3);
    // 6: overwork streak
    do_start();
    send(96, 10, 0);
    send(97, 10, 0);
    send(98, 10, 0);
    send(50, 10, 0);
`ifdef STAGE_CHAIN_LIVER_CHECK_EN
    chk("t6_liver_fail", liver_fail, 1);
    chk("t6_fail_stage", fail_stage, 2);
    chk("t6_pass", pass, 0);
`else
    chk("t6_liver_fail", liver_fail, 0);
    chk("t6_pass", pass, 1);
    chk("t6_final_bonus", final_bonus, 1);
`endif
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
